// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and the width of the memory-wait counter.
package hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // Wide enough for the largest legal MEM_TIMEOUT (255).
  localparam int WAIT_W = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; the value is registered and
// the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirects, memory-wait freeze
// with timeout halt. Controls are combinational (zero latency); state and counters are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_ID_Reg1,
  input  logic [4:0]       i_ID_Reg2,
  input  logic             i_ID_UsesReg1,
  input  logic             i_ID_UsesReg2,
  input  logic [4:0]       i_EX_RegDst,
  input  logic             i_EX_MemToReg,
  input  logic             i_EX_RegWrEn,
  input  logic             i_EX_Redirect,
  input  logic             i_MemReq,
  input  logic             i_MemReady,
  output logic             o_PcEn,
  output logic             o_IfIdEn,
  output logic             o_IdExEn,
  output logic             o_ExMemEn,
  output logic             o_IfIdFlush,
  output logic             o_IdExFlush,
  output logic             o_PcSel,
  output logic             o_Halted,
  output logic [CNT_W-1:0] o_StallCycles,
  output logic [CNT_W-1:0] o_FlushCount
);

  localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W+1)'(MEM_TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              redir_pend_q, redir_pend_d;
  logic [WAIT_W:0]   wait_next;
  logic              mem_wait, load_use, redir;
  logic              stall_inc, flush_inc;

  always_comb begin
    mem_wait  = i_MemReq && !i_MemReady;
    load_use  = i_EX_MemToReg && i_EX_RegWrEn && (i_EX_RegDst != 5'd0) &&
                ((i_ID_UsesReg1 && (i_ID_Reg1 == i_EX_RegDst)) ||
                 (i_ID_UsesReg2 && (i_ID_Reg2 == i_EX_RegDst)));
    // A redirect that arrived during a memory wait is replayed once the wait clears.
    redir     = i_EX_Redirect || redir_pend_q;
    wait_next = {1'b0, wait_cnt_q} + (WAIT_W+1)'(1);

    o_PcEn       = 1'b1;
    o_IfIdEn     = 1'b1;
    o_IdExEn     = 1'b1;
    o_ExMemEn    = 1'b1;
    o_IfIdFlush  = 1'b0;
    o_IdExFlush  = 1'b0;
    o_PcSel      = 1'b0;
    o_Halted     = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    redir_pend_d = redir_pend_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (reset) begin
      o_PcEn       = 1'b0;
      o_IfIdEn     = 1'b0;
      o_IdExEn     = 1'b0;
      o_ExMemEn    = 1'b0;
      o_IfIdFlush  = 1'b1;
      o_IdExFlush  = 1'b1;
      state_d      = ST_RUN;
      wait_cnt_d   = '0;
      redir_pend_d = 1'b0;
    end else if (state_q == ST_HALT) begin
      o_PcEn    = 1'b0;
      o_IfIdEn  = 1'b0;
      o_IdExEn  = 1'b0;
      o_ExMemEn = 1'b0;
      o_Halted  = 1'b1;
    end else if (mem_wait) begin
      o_PcEn     = 1'b0;
      o_IfIdEn   = 1'b0;
      o_IdExEn   = 1'b0;
      o_ExMemEn  = 1'b0;
      stall_inc  = 1'b1;
      wait_cnt_d = wait_next[WAIT_W-1:0];
      if (i_EX_Redirect) begin
        redir_pend_d = 1'b1;
      end
      state_d = (wait_next >= TIMEOUT_LIM) ? ST_HALT : ST_MEM_WAIT;
    end else begin
      state_d    = ST_RUN;
      wait_cnt_d = '0;
      if (redir) begin
        o_PcSel      = 1'b1;
        o_IfIdFlush  = 1'b1;
        o_IdExFlush  = 1'b1;
        flush_inc    = 1'b1;
        redir_pend_d = 1'b0;
      end else if (load_use) begin
        o_PcEn      = 1'b0;
        o_IfIdEn    = 1'b0;
        o_IdExFlush = 1'b1;
        stall_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    wait_cnt_q   <= wait_cnt_d;
    redir_pend_q <= redir_pend_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .cnt (o_StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc),
    .cnt (o_FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed corner sequences and random
// traffic, all checked against a behavioural model of the control rules.
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    i_ID_Reg1, i_ID_Reg2, i_EX_RegDst;
  logic          i_ID_UsesReg1, i_ID_UsesReg2;
  logic          i_EX_MemToReg, i_EX_RegWrEn, i_EX_Redirect;
  logic          i_MemReq, i_MemReady;
  logic          o_PcEn, o_IfIdEn, o_IdExEn, o_ExMemEn;
  logic          o_IfIdFlush, o_IdExFlush, o_PcSel, o_Halted;
  logic [CW-1:0] o_StallCycles, o_FlushCount;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_ID_Reg1(i_ID_Reg1), .i_ID_Reg2(i_ID_Reg2),
    .i_ID_UsesReg1(i_ID_UsesReg1), .i_ID_UsesReg2(i_ID_UsesReg2),
    .i_EX_RegDst(i_EX_RegDst), .i_EX_MemToReg(i_EX_MemToReg),
    .i_EX_RegWrEn(i_EX_RegWrEn), .i_EX_Redirect(i_EX_Redirect),
    .i_MemReq(i_MemReq), .i_MemReady(i_MemReady),
    .o_PcEn(o_PcEn), .o_IfIdEn(o_IfIdEn), .o_IdExEn(o_IdExEn), .o_ExMemEn(o_ExMemEn),
    .o_IfIdFlush(o_IfIdFlush), .o_IdExFlush(o_IdExFlush), .o_PcSel(o_PcSel),
    .o_Halted(o_Halted), .o_StallCycles(o_StallCycles), .o_FlushCount(o_FlushCount)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model state: halted flag, consecutive wait cycles, deferred redirect.
  bit   m_halt;
  int   m_wait;
  bit   m_pend;
  int   m_stall;
  int   m_flush;
  logic [7:0] s_out;

  // Output packing: {PcEn, IfIdEn, IdExEn, ExMemEn, IfIdFlush, IdExFlush, PcSel, Halted}
  localparam logic [7:0] OUT_RST  = 8'b0000_1100;
  localparam logic [7:0] OUT_HALT = 8'b0000_0001;
  localparam logic [7:0] OUT_WAIT = 8'b0000_0000;
  localparam logic [7:0] OUT_REDR = 8'b1111_1110;
  localparam logic [7:0] OUT_LU   = 8'b0011_0100;
  localparam logic [7:0] OUT_RUN  = 8'b1111_0000;

  typedef struct {
    logic [4:0] r1, r2, dst;
    logic       u1, u2, mtr, wr, redir, mreq, mrdy;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit lu_hazard();
    if (!(i_EX_MemToReg && i_EX_RegWrEn) || i_EX_RegDst == 5'd0) return 1'b0;
    return (i_ID_UsesReg1 && i_ID_Reg1 == i_EX_RegDst) ||
           (i_ID_UsesReg2 && i_ID_Reg2 == i_EX_RegDst);
  endfunction

  function automatic logic [7:0] exp_out();
    if (reset)                     return OUT_RST;
    if (m_halt)                    return OUT_HALT;
    if (i_MemReq && !i_MemReady)   return OUT_WAIT;
    if (i_EX_Redirect || m_pend)   return OUT_REDR;
    if (lu_hazard())               return OUT_LU;
    return OUT_RUN;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_halt = 0; m_wait = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      if (i_MemReq && !i_MemReady) begin
        m_wait++;
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (i_EX_Redirect) m_pend = 1;
        if (m_wait >= TO) m_halt = 1;
      end else begin
        m_wait = 0;
        if (i_EX_Redirect || m_pend) begin
          m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
          m_pend  = 0;
        end else if (lu_hazard()) begin
          m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end
      end
    end
  endtask

  // One clock: sample at negedge, compare with model, advance model across the edge.
  task automatic cyc(input string nm);
    @(negedge clk);
    s_out = {o_PcEn, o_IfIdEn, o_IdExEn, o_ExMemEn, o_IfIdFlush, o_IdExFlush, o_PcSel, o_Halted};
    chk({nm, "_ctl"}, 32'(s_out), 32'(exp_out()));
    chk({nm, "_stall"}, 32'(o_StallCycles), 32'(m_stall));
    chk({nm, "_flush"}, 32'(o_FlushCount), 32'(m_flush));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_ID_Reg1 = 0; i_ID_Reg2 = 0; i_EX_RegDst = 0;
    i_ID_UsesReg1 = 0; i_ID_UsesReg2 = 0;
    i_EX_MemToReg = 0; i_EX_RegWrEn = 0; i_EX_Redirect = 0;
    i_MemReq = 0; i_MemReady = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc("rst");
    reset = 0;
  endtask

  task automatic set_lw_hazard(input logic [4:0] dst);
    i_EX_MemToReg = 1; i_EX_RegWrEn = 1; i_EX_RegDst = dst;
    i_ID_Reg1 = 5; i_ID_Reg2 = 1; i_ID_UsesReg1 = 1; i_ID_UsesReg2 = 1;
  endtask

  vec_t vecs[11];

  initial begin
    idle();
    reset = 1;
    m_halt = 0; m_wait = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
    cyc("reset_state");
    reset = 0;

    //           r1  r2 dst u1 u2 mtr wr rd mq my  expected
    vecs[0]  = '{5'd1, 5'd2, 5'd3, 1, 1, 1, 1, 0, 0, 0, OUT_RUN};
    vecs[1]  = '{5'd5, 5'd1, 5'd5, 1, 1, 1, 1, 0, 0, 0, OUT_LU};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 0, 0, 0, OUT_RUN};
    vecs[3]  = '{5'd1, 5'd7, 5'd7, 0, 1, 1, 1, 0, 0, 0, OUT_LU};
    vecs[4]  = '{5'd5, 5'd1, 5'd5, 0, 1, 1, 1, 0, 0, 0, OUT_RUN};
    vecs[5]  = '{5'd5, 5'd1, 5'd5, 1, 1, 0, 1, 0, 0, 0, OUT_RUN};
    vecs[6]  = '{5'd5, 5'd1, 5'd5, 1, 1, 1, 0, 0, 0, 0, OUT_RUN};
    vecs[7]  = '{5'd5, 5'd1, 5'd5, 1, 1, 1, 1, 1, 0, 0, OUT_REDR};
    vecs[8]  = '{5'd5, 5'd1, 5'd5, 1, 1, 1, 1, 1, 1, 0, OUT_WAIT};
    vecs[9]  = '{5'd5, 5'd1, 5'd5, 1, 1, 1, 1, 0, 1, 1, OUT_LU};
    vecs[10] = '{5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, 1, OUT_RUN};

    for (int v = 0; v < 11; v++) begin
      do_reset();
      i_ID_Reg1 = vecs[v].r1; i_ID_Reg2 = vecs[v].r2; i_EX_RegDst = vecs[v].dst;
      i_ID_UsesReg1 = vecs[v].u1; i_ID_UsesReg2 = vecs[v].u2;
      i_EX_MemToReg = vecs[v].mtr; i_EX_RegWrEn = vecs[v].wr;
      i_EX_Redirect = vecs[v].redir; i_MemReq = vecs[v].mreq; i_MemReady = vecs[v].mrdy;
      cyc($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_table", v), 32'(s_out), 32'(vecs[v].exp));
    end

    // Load-use stall for one cycle, then the same pair with x0 as destination.
    do_reset();
    set_lw_hazard(5'd5);
    cyc("lu");
    chk("lu_stall_cnt", 32'(o_StallCycles), 32'd1);
    set_lw_hazard(5'd0);
    i_ID_Reg1 = 0;
    cyc("lu_x0");
    chk("lu_x0_no_stall", 32'(s_out), 32'(OUT_RUN));
    chk("lu_x0_stall_cnt", 32'(o_StallCycles), 32'd1);

    // Single redirect.
    do_reset();
    i_EX_Redirect = 1;
    cyc("redir");
    chk("redir_out", 32'(s_out), 32'(OUT_REDR));
    chk("redir_flush_cnt", 32'(o_FlushCount), 32'd1);

    // Three wait cycles then ready.
    do_reset();
    i_MemReq = 1; i_MemReady = 0;
    for (int k = 0; k < 3; k++) begin
      cyc("mw");
      chk("mw_frozen", 32'(s_out), 32'(OUT_WAIT));
    end
    i_MemReady = 1;
    cyc("mw_done");
    chk("mw_done_run", 32'(s_out), 32'(OUT_RUN));
    chk("mw_stall_cnt", 32'(o_StallCycles), 32'd3);

    // Timeout into halt, sticky until reset.
    do_reset();
    i_MemReq = 1; i_MemReady = 0;
    for (int k = 0; k < TO; k++) cyc("to_wait");
    chk("to_stall_cnt", 32'(o_StallCycles), 32'(TO));
    i_MemReady = 1;
    cyc("halt_a");
    chk("halt_sticky_a", 32'(s_out), 32'(OUT_HALT));
    idle();
    i_EX_Redirect = 1;
    cyc("halt_b");
    chk("halt_sticky_b", 32'(s_out), 32'(OUT_HALT));
    chk("halt_no_count", 32'(o_StallCycles), 32'(TO));
    do_reset();
    chk("halt_reset_cnt", 32'(o_StallCycles), 32'd0);
    idle();
    cyc("post_halt");
    chk("post_halt_run", 32'(s_out), 32'(OUT_RUN));

    // Redirect concurrent with two wait cycles, replayed afterwards.
    do_reset();
    i_EX_Redirect = 1; i_MemReq = 1; i_MemReady = 0;
    for (int k = 0; k < 2; k++) begin
      cyc("rw");
      chk("rw_held", 32'(s_out[1]), 32'd0);
    end
    idle();
    cyc("rw_release");
    chk("rw_pcsel", 32'(s_out[1]), 32'd1);
    chk("rw_flush_cnt", 32'(o_FlushCount), 32'd1);

    // Counter saturation.
    do_reset();
    set_lw_hazard(5'd5);
    for (int k = 0; k < 20; k++) cyc("sat");
    chk("sat_stall_cnt", 32'(o_StallCycles), 32'hF);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      reset         = ($urandom_range(0, 59) == 0);
      i_ID_Reg1     = 5'($urandom_range(0, 3));
      i_ID_Reg2     = 5'($urandom_range(0, 3));
      i_EX_RegDst   = 5'($urandom_range(0, 3));
      i_ID_UsesReg1 = 1'($urandom_range(0, 1));
      i_ID_UsesReg2 = 1'($urandom_range(0, 1));
      i_EX_MemToReg = 1'($urandom_range(0, 1));
      i_EX_RegWrEn  = ($urandom_range(0, 3) != 0);
      i_EX_Redirect = ($urandom_range(0, 5) == 0);
      i_MemReq      = ($urandom_range(0, 2) == 0);
      i_MemReady    = ($urandom_range(0, 2) == 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max consecutive MEM_WAIT cycles before halt (legal 1..255).
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i_ID_Reg1 / i_ID_Reg2  in  5 each  decode-stage source register indices.
REQ-007 i_ID_UsesReg1 / i_ID_UsesReg2  in  1 each  decode instruction actually reads rs1/rs2.
REQ-008 i_EX_RegDst  in  5  destination register of instruction in EX.
REQ-009 i_EX_MemToReg, i_EX_RegWrEn  in  1 each  EX instruction is a load / writes a register.
REQ-010 i_EX_Redirect  in  1  taken branch or jump resolved in EX.
REQ-011 i_MemReq, i_MemReady  in  1 each  MEM-stage data access pending / data memory completes access this cycle.
REQ-012 o_PcEn, o_IfIdEn, o_IdExEn, o_ExMemEn  out  1 each  stage register enables.
REQ-013 o_IfIdFlush, o_IdExFlush  out  1 each  load bubble into stage register.
REQ-014 o_PcSel  out  1  select EX redirect target as next PC.
REQ-015 o_Halted  out  1  sticky memory-timeout halt.
REQ-016 o_StallCycles, o_FlushCount  out  CNT_W each  performance counters.

Function
REQ-017 FSM states SHALL be RUN, MEM_WAIT, HALT; state register and counters update on rising clk only.
REQ-018 Control outputs SHALL be combinational from current state and inputs (same-cycle response, zero latency).
REQ-019 Default in RUN: all enables 1, flushes 0, o_PcSel 0.
REQ-020 Priority per cycle: HALT > memory wait > redirect > load-use.
REQ-021 Memory wait: i_MemReq=1 and i_MemReady=0 SHALL drive all four enables 0, flushes 0, o_PcSel 0, and enter/stay MEM_WAIT.
REQ-022 MEM_WAIT exits to RUN in the cycle i_MemReady=1 (outputs revert to RUN rules that cycle); i_MemReq dropping also exits.
REQ-023 Wait counter SHALL count cycles in MEM_WAIT; reaching MEM_TIMEOUT with i_MemReady still 0 SHALL move to HALT.
REQ-024 HALT: all enables 0, flushes 0, o_PcSel 0, o_Halted 1; exit only via reset.
REQ-025 Redirect (RUN, no memory wait, i_EX_Redirect=1): o_PcSel 1, o_IfIdFlush 1, o_IdExFlush 1, enables 1; load-use ignored that cycle.
REQ-026 Load-use: i_EX_MemToReg & i_EX_RegWrEn & i_EX_RegDst!=0 & ((i_ID_UsesReg1 & i_ID_Reg1==i_EX_RegDst) | (i_ID_UsesReg2 & i_ID_Reg2==i_EX_RegDst)) SHALL give o_PcEn 0, o_IfIdEn 0, o_IdExFlush 1, o_ExMemEn 1.
REQ-027 Destination x0 SHALL never cause a stall.
REQ-028 o_StallCycles +1 per cycle with load-use stall or memory wait (HALT excluded); o_FlushCount +1 per redirect cycle.
REQ-029 Counters SHALL saturate at all-ones, never wrap.
REQ-030 Memory wait concurrent with redirect: redirect held off (o_PcSel 0) and honoured in the first non-wait cycle.

Reset
REQ-031 While reset=1: state RUN, wait counter 0, counters 0, o_Halted 0, all enables 0, both flushes 1, o_PcSel 0.
REQ-032 Reset asserted mid-MEM_WAIT or in HALT SHALL return to RUN on the next edge, clearing o_Halted.

Structure
REQ-033 State encodings (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2) SHALL be defined in the shared rv32i definitions header.
REQ-034 One sub-module, sat_counter (parameterised width, synchronous clear, increment enable), instantiated twice for the performance counters.

Verification
REQ-035 EX lw x5, ID add x6,x5,x1 (UsesReg1=1) -> one cycle PcEn=0, IfIdEn=0, IdExFlush=1; StallCycles=1; same with RegDst=0 -> no stall.
REQ-036 i_EX_Redirect=1 in RUN -> PcSel=1, IfIdFlush=IdExFlush=1 that cycle; FlushCount=1.
REQ-037 MemReq=1, MemReady=0 for 3 cycles then 1 -> enables 0 for 3 cycles, RUN on 4th; StallCycles=3.
REQ-038 MEM_TIMEOUT=4, MemReady held 0 -> HALT after 4 wait cycles, o_Halted=1 until reset; reset -> RUN, counters 0.
REQ-039 Redirect and memory wait together for 2 cycles -> PcSel=0 both, PcSel=1 on the first non-wait cycle.
REQ-040 CNT_W=4, 20 stall cycles -> o_StallCycles holds 4'hF.
